// File: rtl/fm0_tag_rx_if.sv
// Bundle between the reader controller and the FM0 backscatter receiver:
// arming level and tag line in, decoded bytes and frame status out.
interface fm0_tag_rx_if;
    logic       rx_en;
    logic       tag_data;
    logic [7:0] rx_byte;
    logic       rx_byte_vld;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_len;
    logic       rx_busy;

    modport master (
        output rx_en, tag_data,
        input  rx_byte, rx_byte_vld, rx_done, rx_err, rx_len, rx_busy
    );

    modport slave (
        input  rx_en, tag_data,
        output rx_byte, rx_byte_vld, rx_done, rx_err, rx_len, rx_busy
    );
endinterface

// File: rtl/fm0_tag_rx.sv
// FM0 baseband receiver: synchronises the tag line, times edge intervals,
// checks the preamble and emits payload bytes, closing each frame with done/err.
module fm0_tag_rx #(
    parameter int                 HALF_CYC    = 400,
    parameter int                 TOL_CYC     = 100,
    parameter int                 TIMEOUT_CYC = 1600,
    parameter int                 PRE_LEN     = 6,
    parameter logic [PRE_LEN-1:0] PREAMBLE    = 6'b101011
) (
    input logic        clk_50m,
    input logic        rst_n,
    fm0_tag_rx_if.slave bus
);

    localparam int                PCNT_W    = $clog2(PRE_LEN);
    localparam logic [11:0]       SHORT_MIN = 12'(HALF_CYC - TOL_CYC);
    localparam logic [11:0]       SHORT_MAX = 12'(HALF_CYC + TOL_CYC);
    localparam logic [11:0]       LONG_MIN  = 12'(2 * HALF_CYC - TOL_CYC);
    localparam logic [11:0]       LONG_MAX  = 12'(2 * HALF_CYC + TOL_CYC);
    localparam logic [11:0]       TMO_C     = 12'(TIMEOUT_CYC);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRE_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PRE, S_DATA, S_ERR, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic               r_sync1, r_sync2, r_sync3;
    logic [11:0]        r_cnt;
    logic [11:0]        w_ival;
    logic               w_edge, w_short, w_long, w_bad, w_tmo;
    logic               w_bit_vld, w_bit, w_dec_err, w_pre_ok, w_term_ok;
    logic               r_half;
    logic [PRE_LEN-1:0] r_pre_sr;
    logic [PCNT_W-1:0]  r_pcnt;
    logic               r_hold, r_hold_vld;
    logic [6:0]         r_sr;
    logic [2:0]         r_bcnt;
    logic [7:0]         r_byte, r_len;
    logic               r_vld;
    logic               w_busy, w_done, w_err;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= bus.tag_data;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 ^ r_sync3;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)                r_cnt <= '0;
        else if (w_edge)           r_cnt <= '0;
        else if (r_cnt != TMO_C)   r_cnt <= r_cnt + 12'd1;
    end

    // r_cnt restarts at 0 the cycle after an edge, so +1 gives the true spacing
    assign w_ival    = r_cnt + 12'd1;
    assign w_short   = (w_ival >= SHORT_MIN) && (w_ival <= SHORT_MAX);
    assign w_long    = (w_ival >= LONG_MIN)  && (w_ival <= LONG_MAX);
    assign w_bad     = !w_short && !w_long;
    assign w_tmo     = !w_edge && (r_cnt == TMO_C);
    assign w_bit_vld = w_edge && ((w_long && !r_half) || (w_short && r_half));
    assign w_bit     = w_long;
    assign w_dec_err = w_edge && (w_bad || (w_long && r_half));
    assign w_pre_ok  = (w_bit == r_pre_sr[PRE_LEN-1]);
    assign w_term_ok = r_hold_vld && r_hold && (r_bcnt == 3'd0) && !r_half;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!bus.rx_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_ARMED;
                S_ARMED: if (w_edge) w_state_nxt = S_PRE;
                S_PRE: begin
                    if (w_dec_err || w_tmo || (w_bit_vld && !w_pre_ok)) w_state_nxt = S_ERR;
                    else if (w_bit_vld && (r_pcnt == PCNT_LAST))        w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (w_dec_err)  w_state_nxt = S_ERR;
                    else if (w_tmo) w_state_nxt = w_term_ok ? S_DONE : S_ERR;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_PRE, S_DATA: w_busy = 1'b1;
            S_ERR:         w_err  = bus.rx_en;
            S_DONE:        w_done = bus.rx_en;
            default:       ;
        endcase
    end

    // Each decoded payload bit is held back one slot so the trailing dummy bit
    // never reaches the byte shifter.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_half     <= 1'b0;
            r_pre_sr   <= '0;
            r_pcnt     <= '0;
            r_hold     <= 1'b0;
            r_hold_vld <= 1'b0;
            r_sr       <= '0;
            r_bcnt     <= '0;
            r_byte     <= '0;
            r_len      <= '0;
            r_vld      <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (!bus.rx_en) begin
                r_len      <= '0;
                r_half     <= 1'b0;
                r_hold_vld <= 1'b0;
                r_bcnt     <= '0;
            end else if (r_state == S_ARMED) begin
                if (w_edge) begin
                    r_len      <= '0;
                    r_half     <= 1'b0;
                    r_hold_vld <= 1'b0;
                    r_bcnt     <= '0;
                    r_pcnt     <= '0;
                    r_pre_sr   <= PREAMBLE;
                end
            end else if ((r_state == S_PRE) || (r_state == S_DATA)) begin
                if (w_edge && w_short) r_half <= !r_half;
                if (w_bit_vld && (r_state == S_PRE)) begin
                    r_pre_sr <= r_pre_sr << 1;
                    r_pcnt   <= r_pcnt + PCNT_ONE;
                end
                if (w_bit_vld && (r_state == S_DATA)) begin
                    r_hold     <= w_bit;
                    r_hold_vld <= 1'b1;
                    if (r_hold_vld) begin
                        r_sr   <= {r_sr[5:0], r_hold};
                        r_bcnt <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7) begin
                            r_byte <= {r_sr, r_hold};
                            r_vld  <= 1'b1;
                            if (r_len != 8'hFF) r_len <= r_len + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.rx_byte     = r_byte;
    assign bus.rx_byte_vld = r_vld;
    assign bus.rx_len      = r_len;
    assign bus.rx_busy     = w_busy;
    assign bus.rx_done     = w_done;
    assign bus.rx_err      = w_err;

endmodule

// File: tb/tb_fm0_tag_rx.sv
// Randomised and directed frames for fm0_tag_rx, scored against a bit-list
// reference decoder; timing parameters are scaled down to keep runs short.
module tb_fm0_tag_rx;

    localparam int         H   = 40;
    localparam int         T   = 10;
    localparam int         TMO = 160;
    localparam int         PL  = 6;
    localparam logic [5:0] PRE = 6'b101011;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50m = ~clk_50m;

    fm0_tag_rx_if bus();

    fm0_tag_rx #(
        .HALF_CYC(H), .TOL_CYC(T), .TIMEOUT_CYC(TMO), .PRE_LEN(PL), .PREAMBLE(PRE)
    ) dut (
        .clk_50m(clk_50m),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] got_bytes[$];
    int         got_done = 0;
    int         got_err  = 0;
    logic [7:0] exp_bytes[$];
    int         exp_done, exp_err;
    bit         fbits[$];
    int         ivals[$];

    always @(negedge clk_50m) begin
        if (bus.rx_byte_vld) got_bytes.push_back(bus.rx_byte);
        if (bus.rx_done)     got_done++;
        if (bus.rx_err)      got_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int urange(input int lo, input int hi);
        return lo + int'($urandom % 32'(hi - lo + 1));
    endfunction

    // 1 = half-bit, 2 = full-bit, 0 = out of both windows
    function automatic int cls(input int v);
        if (v >= H - T && v <= H + T)         return 1;
        if (v >= 2 * H - T && v <= 2 * H + T) return 2;
        return 0;
    endfunction

    task automatic add_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fbits.push_back(v[i]);
    endtask

    task automatic build(input int s_lo, input int s_hi, input int l_lo, input int l_hi);
        ivals.delete();
        foreach (fbits[i]) begin
            if (fbits[i]) ivals.push_back(urange(l_lo, l_hi));
            else begin
                ivals.push_back(urange(s_lo, s_hi));
                ivals.push_back(urange(s_lo, s_hi));
            end
        end
    endtask

    function automatic int n_ivals(input int nbits);
        int n = 0;
        for (int i = 0; i < nbits; i++) n += fbits[i] ? 1 : 2;
        return n;
    endfunction

    // Reference: decode the interval list into bits, then apply the frame rules.
    task automatic model();
        bit         bq[$];
        bit         derr = 0, dang = 0;
        int         k = 0, n, nby;
        logic [5:0] pv = PRE;
        logic [7:0] by;
        exp_bytes.delete();
        exp_done = 0;
        exp_err  = 0;
        while (k < ivals.size()) begin
            if (cls(ivals[k]) == 2) begin
                bq.push_back(1'b1); k++;
            end else if (cls(ivals[k]) == 1 && k + 1 == ivals.size()) begin
                dang = 1; k++;
            end else if (cls(ivals[k]) == 1 && cls(ivals[k + 1]) == 1) begin
                bq.push_back(1'b0); k += 2;
            end else begin
                derr = 1; k = ivals.size();
            end
        end
        if (bq.size() < PL) begin exp_err = 1; return; end
        for (int i = 0; i < PL; i++)
            if (bq[i] != pv[PL - 1 - i]) begin exp_err = 1; return; end
        n   = bq.size() - PL;
        nby = (n > 0) ? (n - 1) / 8 : 0;
        for (int b = 0; b < nby; b++) begin
            by = '0;
            for (int j = 0; j < 8; j++) by = {by[6:0], bq[PL + 8 * b + j]};
            exp_bytes.push_back(by);
        end
        if (derr || dang || n == 0 || !bq[bq.size() - 1] || ((n - 1) % 8) != 0) exp_err = 1;
        else exp_done = 1;
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        got_done = 0;
        got_err  = 0;
    endtask

    task automatic drive(input int lim);
        @(negedge clk_50m);
        bus.tag_data = ~bus.tag_data;
        for (int i = 0; i < lim; i++) begin
            repeat (ivals[i]) @(negedge clk_50m);
            if (got_err != 0) break;
            bus.tag_data = ~bus.tag_data;
        end
    endtask

    task automatic run_frame(input string nm);
        model();
        clear_mon();
        drive(ivals.size());
        repeat (TMO + 40) @(negedge clk_50m);
        check({nm, " done"}, got_done, exp_done);
        check({nm, " err"}, got_err, exp_err);
        check({nm, " nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check({nm, " byte"}, got_bytes[i], exp_bytes[i]);
        if (exp_done != 0) check({nm, " len"}, bus.rx_len, exp_bytes.size());
        check({nm, " busy"}, bus.rx_busy, 0);
    endtask

    task automatic clean_frame();
        fbits.delete();
        add_bits(8'(PRE), PL);
        add_bits(8'hA5, 8);
        add_bits(8'h3C, 8);
        fbits.push_back(1'b1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " byte0"}, bus.rx_byte, 0);
        check({nm, " vld0"}, bus.rx_byte_vld, 0);
        check({nm, " done0"}, bus.rx_done, 0);
        check({nm, " err0"}, bus.rx_err, 0);
        check({nm, " len0"}, bus.rx_len, 0);
        check({nm, " busy0"}, bus.rx_busy, 0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k, nb;
        logic [5:0] p;
        bus.rx_en    = 1'b0;
        bus.tag_data = 1'b1;
        repeat (3) @(negedge clk_50m);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);
        bus.rx_en = 1'b1;
        repeat (4) @(negedge clk_50m);

        clean_frame();
        build(H, H, 2 * H, 2 * H);
        run_frame("clean");
        check("clean len2", bus.rx_len, 2);

        build(H - T, H - T, 2 * H + T, 2 * H + T);
        run_frame("tol_wide");
        build(H + T, H + T, 2 * H - T, 2 * H - T);
        run_frame("tol_tight");

        build(H - T, H - T, 2 * H + T, 2 * H + T);
        k = 0;
        foreach (ivals[i]) if (ivals[i] == H - T) k = i;
        ivals[k] = H - T - 1;
        run_frame("tol_short");
        check("tol_short errpulse", got_err, 1);

        fbits.delete();
        add_bits(8'b101010, PL);
        add_bits(8'hA5, 8);
        fbits.push_back(1'b1);
        build(H, H, 2 * H, 2 * H);
        run_frame("pre_bad");

        fbits.delete();
        add_bits(8'(PRE), PL);
        add_bits(8'hFF, 8);
        add_bits(8'b111, 3);
        build(H, H, 2 * H, 2 * H);
        run_frame("extra_bits");

        clean_frame();
        void'(fbits.pop_back());
        fbits.push_back(1'b0);
        build(H, H, 2 * H, 2 * H);
        run_frame("dummy0");

        // abort partway through the second byte
        clean_frame();
        build(H, H, 2 * H, 2 * H);
        k = n_ivals(PL + 12);
        clear_mon();
        drive(k);
        repeat (20) @(negedge clk_50m);
        check("abort busy_before", bus.rx_busy, 1);
        bus.rx_en = 1'b0;
        @(negedge clk_50m);
        check("abort busy_after", bus.rx_busy, 0);
        for (int i = k; i < ivals.size(); i++) begin
            repeat (ivals[i]) @(negedge clk_50m);
            bus.tag_data = ~bus.tag_data;
        end
        repeat (TMO + 40) @(negedge clk_50m);
        check("abort nbytes", got_bytes.size(), 1);
        if (got_bytes.size() > 0) check("abort byte", got_bytes[0], 8'hA5);
        check("abort done", got_done, 0);
        check("abort err", got_err, 0);
        bus.tag_data = 1'b1;
        repeat (5) @(negedge clk_50m);
        bus.rx_en = 1'b1;
        repeat (4) @(negedge clk_50m);
        clean_frame();
        build(H, H, 2 * H, 2 * H);
        run_frame("rearm");

        // asynchronous reset in the middle of the payload
        clean_frame();
        build(H, H, 2 * H, 2 * H);
        clear_mon();
        drive(n_ivals(PL + 10));
        repeat (5) @(negedge clk_50m);
        check("rst pre_len", bus.rx_len, 1);
        check("rst pre_byte", bus.rx_byte, 8'hA5);
        check("rst pre_busy", bus.rx_busy, 1);
        @(negedge clk_50m);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        bus.tag_data = 1'b1;
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50m);
        check("rst quiet", got_done + got_err, 0);
        clean_frame();
        build(H, H, 2 * H, 2 * H);
        run_frame("post_rst");

        for (int r = 0; r < 12; r++) begin
            fbits.delete();
            p = PRE;
            if ($urandom % 6 == 0) p[urange(0, PL - 1)] ^= 1'b1;
            add_bits(8'(p), PL);
            nb = urange(0, 2);
            for (int b = 0; b < nb; b++) add_bits(8'($urandom), 8);
            if ($urandom % 5 == 0) add_bits(8'($urandom), urange(1, 3));
            fbits.push_back(($urandom % 5 == 0) ? 1'($urandom) : 1'b1);
            build(H - T, H + T, 2 * H - T, 2 * H + T);
            if ($urandom % 4 == 0) ivals[urange(0, ivals.size() - 1)] = urange(H - 2 * T, 2 * H + 2 * T);
            run_frame("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fm0_tag_rx.md
Name: fm0_tag_rx

Overview:
- Reader-side receiver for tag backscatter inside the reader emulator.
- Samples the serial tag_data line driven by the tag core and decodes FM0 baseband.
- Checks a fixed preamble, then delivers payload bytes to the reader controller with a valid pulse.
- Ends each frame with a done or error pulse. It is the receive end of the tag's FM0 transmitter.

Parameters:
HALF_CYC, 400, nominal half-bit period in clk_50m cycles (BLF 62.5 kHz)
TOL_CYC, 100, +/- tolerance applied to half and full intervals
TIMEOUT_CYC, 1600, cycles without an edge that end a frame
PRE_LEN, 6, preamble length in bits
PREAMBLE, 6'b101011, expected preamble bits, MSB first

Ports:
clk_50m  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
rx_en  input  1  level; high = armed/receiving, low = abort and return to IDLE
tag_data  input  1  asynchronous FM0 line from tag
rx_byte  output  8  decoded payload byte, MSB first on line
rx_byte_vld  output  1  one-cycle pulse; rx_byte valid
rx_done  output  1  one-cycle pulse, frame ended cleanly
rx_err  output  1  one-cycle pulse, frame aborted on error
rx_len  output  8  payload byte count of last frame, valid from rx_done until next frame start
rx_busy  output  1  high from first edge until done/err

Behaviour:
- Reset: all outputs 0; state IDLE; sync flops reset to 1 (line idles high).
- tag_data passes through a 2-flop synchronizer plus an edge-detect flop; an edge is any change of the synchronized value. Edge-to-logic latency is 3 cycles.
- Interval counter: 12 bits, cleared on every edge, saturates at TIMEOUT_CYC.
- Edge classification, using the counter value at the edge:
  - SHORT: in [HALF_CYC-TOL_CYC, HALF_CYC+TOL_CYC].
  - LONG: in [2*HALF_CYC-TOL_CYC, 2*HALF_CYC+TOL_CYC].
  - Anything else is BAD.
- Decode rules:
  - LONG = bit 1.
  - SHORT followed by SHORT = bit 0.
  - SHORT followed by LONG or BAD = error.
  - A half-bit flag tracks a pending first SHORT.
- States:
  - IDLE: wait for rx_en=1, then go to ARMED.
  - ARMED: the first edge starts the counter, sets rx_busy and clears rx_len, then go to PRE. No timeout applies in ARMED.
  - PRE: compare each decoded bit to PREAMBLE[PRE_LEN-1-i]. A mismatch goes to ERR. After PRE_LEN matching bits, go to DATA.
  - DATA: each decoded bit enters a 1-bit hold stage. When a new bit arrives, the held bit shifts into an 8-bit shift register. The 8th shifted bit outputs rx_byte with rx_byte_vld the same cycle and increments rx_len, which saturates at 255.
  - DATA timeout (counter reaches TIMEOUT_CYC):
    - The held bit is the FM0 dummy bit and must be 1.
    - The bit count in the shift register must be 0.
    - The half-bit flag must be clear.
    - If all hold, pulse rx_done; otherwise pulse rx_err.
    - A timeout with no held bit (zero payload bits) is an error.
  - ERR: pulse rx_err for one cycle, clear rx_busy, then go to IDLE.
  - DONE: pulse rx_done for one cycle, clear rx_busy, then go to IDLE.
  - Re-arming requires rx_en to still be high: IDLE moves to ARMED on the next cycle.
- A timeout in PRE is an error.
- Any BAD interval in PRE or DATA goes to ERR on that edge.
- rx_en falling in any state: immediately go to IDLE with no done/err pulse. rx_busy clears next cycle; partial byte and rx_len are discarded.
- rx_byte holds its value until the next byte. rx_byte_vld and rx_done never assert in the same cycle; the final byte's vld precedes done by at least TIMEOUT_CYC.
- Asynchronous reset mid-frame: everything is cleared immediately, no pulses.

Test Plan:
- Clean frame: preamble 101011, payload 0xA5, 0x3C, dummy 1, nominal 400/800 intervals -> vld pulses with 0xA5 then 0x3C, rx_done once, rx_len=2, rx_err never.
- Tolerance edges: same frame with all shorts 300 and longs 900 -> identical result; repeat with one short at 299 -> rx_err, no rx_done.
- Preamble mismatch: send 101010 -> rx_err after the 6th bit, no vld.
- Bad termination:
  - payload 0xFF plus 3 extra bits then timeout -> rx_err after 0xFF vld;
  - dummy bit 0 -> rx_err.
- Abort: deassert rx_en mid-second byte -> no further vld/done/err; rx_busy low 1 cycle later. Re-enable and send a clean frame -> decodes normally.
- Reset mid-frame: pulse rst_n low during DATA -> all outputs 0 immediately, state IDLE.
